pipe_hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage core. It drives the stall and flush inputs of the PC register, the IF/ID register and the ID/EX register, and the stall input of the EX/MEM register. It resolves load-use hazards, taken-branch redirects and data-memory wait states, and enforces a memory-wait timeout. It also keeps saturating performance counters for stall cycles, bubbles and flushes.

---
 rtl/pipe_hazard_ctrl_if.sv | 37 +++
 rtl/pipe_hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the hazard controller (slave).
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       ex_rd;
  logic             ex_MemREAD;
  logic             ex_branch_taken;
  logic             mem_busy;
  logic             pc_stall;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_ex_stall;
  logic             id_ex_flush;
  logic             ex_mem_stall;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] bubble_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_MemREAD,
           ex_branch_taken, mem_busy,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
           ex_mem_stall, mem_err, stall_cycles, bubble_count, flush_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_MemREAD,
           ex_branch_taken, mem_busy,
    output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
           ex_mem_stall, mem_err, stall_cycles, bubble_count, flush_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush control for the 5-stage core: load-use bubbles, branch squash, memory wait with timeout.
// Control outputs are combinational (zero latency); counters and error state update at the clock edge.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input logic             clk,
  input logic             rst,
  pipe_hazard_ctrl_if.slave hz
);

  localparam int WCW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WCW-1:0]   wait_cnt;
  logic [WCW-1:0]   wait_nxt;
  logic             load_use;
  logic             br_fire;
  logic             bub_fire;
  logic             pc_stall;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_ex_stall;
  logic             id_ex_flush;
  logic             ex_mem_stall;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] bub_q;
  logic [CNT_W-1:0] flush_q;

  assign load_use = hz.ex_MemREAD && (hz.ex_rd != 5'd0) &&
                    ((hz.id_use_rs1 && (hz.ex_rd == hz.id_rs1)) ||
                     (hz.id_use_rs2 && (hz.ex_rd == hz.id_rs2)));

  // Priority order: reset flush, frozen error, memory hold, branch squash, load-use bubble.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    br_fire      = 1'b0;
    bub_fire     = 1'b0;
    if (rst) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (state == ERR || hz.mem_busy) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
    end else if (hz.ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      br_fire     = 1'b1;
    end else if (load_use) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
      bub_fire    = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    case (state)
      RUN: begin
        if (hz.mem_busy) begin
          wait_nxt  = WCW'(1);
          state_nxt = (MEM_TIMEOUT == 1) ? ERR : WAIT;
        end
      end
      WAIT: begin
        if (hz.mem_busy) begin
          if (MEM_TIMEOUT != 0 && (int'(wait_cnt) + 1) == MEM_TIMEOUT) begin
            state_nxt = ERR;
          end else if (wait_cnt != {WCW{1'b1}}) begin
            wait_nxt = wait_cnt + WCW'(1);
          end
        end else begin
          state_nxt = RUN;
          wait_nxt  = '0;
        end
      end
      ERR:     state_nxt = ERR;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // Counters saturate and freeze once the memory timeout has tripped.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      bub_q   <= '0;
      flush_q <= '0;
    end else if (state != ERR) begin
      if (pc_stall && stall_q != {CNT_W{1'b1}}) stall_q <= stall_q + CNT_W'(1);
      if (bub_fire && bub_q != {CNT_W{1'b1}})   bub_q   <= bub_q + CNT_W'(1);
      if (br_fire && flush_q != {CNT_W{1'b1}})  flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign hz.pc_stall     = pc_stall;
  assign hz.if_id_stall  = if_id_stall;
  assign hz.if_id_flush  = if_id_flush;
  assign hz.id_ex_stall  = id_ex_stall;
  assign hz.id_ex_flush  = id_ex_flush;
  assign hz.ex_mem_stall = ex_mem_stall;
  assign hz.mem_err      = (state == ERR);
  assign hz.stall_cycles = stall_q;
  assign hz.bubble_count = bub_q;
  assign hz.flush_count  = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector table, directed corner sequences and random stimulus vs a rule-level model.
module tb_pipe_hazard_ctrl;

  localparam int TO    = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk;
  logic rst;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: consecutive busy-cycle run length, sticky error flag, plain integer counters.
  int m_run   = 0;
  bit m_err   = 1'b0;
  int m_stall = 0;
  int m_bub   = 0;
  int m_flush = 0;

  typedef struct {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic [4:0] rd;
    logic       ld;
    logic       br;
    logic       busy;
    logic [5:0] exp;   // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall}
  } vec_t;

  vec_t vt [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic ld, input logic br, input logic busy);
    rst                = r;
    hz.id_rs1          = rs1;
    hz.id_rs2          = rs2;
    hz.id_use_rs1      = u1;
    hz.id_use_rs2      = u2;
    hz.ex_rd           = rd;
    hz.ex_MemREAD      = ld;
    hz.ex_branch_taken = br;
    hz.mem_busy        = busy;
  endtask

  function automatic logic m_hit();
    return hz.ex_MemREAD && hz.ex_rd != 0 &&
           ((hz.id_use_rs1 && hz.ex_rd == hz.id_rs1) || (hz.id_use_rs2 && hz.ex_rd == hz.id_rs2));
  endfunction

  function automatic logic [5:0] m_ctrl();
    if (rst)                      return 6'b001010;
    if (m_err || hz.mem_busy)     return 6'b110101;
    if (hz.ex_branch_taken)       return 6'b001010;
    if (m_hit())                  return 6'b110010;
    return 6'b000000;
  endfunction

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic m_step(input logic [5:0] c);
    if (rst) begin
      m_run = 0; m_err = 1'b0; m_stall = 0; m_bub = 0; m_flush = 0;
    end else if (!m_err) begin
      if (c[5]) m_stall = sat(m_stall);
      if (!hz.mem_busy && hz.ex_branch_taken) m_flush = sat(m_flush);
      else if (!hz.mem_busy && m_hit())       m_bub   = sat(m_bub);
      if (hz.mem_busy) begin
        m_run++;
        if (TO != 0 && m_run >= TO) m_err = 1'b1;
      end else begin
        m_run = 0;
      end
    end
  endtask

  // Called right after inputs are driven at a falling edge; checks this cycle's
  // control outputs, advances one clock, then checks registered outputs.
  task automatic cycle();
    logic [5:0] exp;
    logic [5:0] act;
    #1;
    exp = m_ctrl();
    act = {hz.pc_stall, hz.if_id_stall, hz.if_id_flush, hz.id_ex_stall, hz.id_ex_flush, hz.ex_mem_stall};
    check("ctrl", 32'(act), 32'(exp));
    @(posedge clk);
    m_step(exp);
    @(negedge clk);
    check("stall_cycles", 32'(hz.stall_cycles), m_stall);
    check("bubble_count", 32'(hz.bubble_count), m_bub);
    check("flush_count",  32'(hz.flush_count),  m_flush);
    check("mem_err",      32'(hz.mem_err),      32'(m_err));
  endtask

  task automatic do_reset();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cycle();
  endtask

  initial begin
    vt[0]  = '{1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 6'b001010};
    vt[1]  = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 6'b000000};
    vt[2]  = '{1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 6'b110010};
    vt[3]  = '{1'b0, 5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 6'b000000};
    vt[4]  = '{1'b0, 5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 6'b110010};
    vt[5]  = '{1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 6'b000000};
    vt[6]  = '{1'b0, 5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 6'b000000};
    vt[7]  = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 6'b001010};
    vt[8]  = '{1'b0, 5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 6'b001010};
    vt[9]  = '{1'b0, 5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1, 6'b110101};
    vt[10] = '{1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1, 6'b001010};

    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    do_reset();
    check("reset_stall_cycles", 32'(hz.stall_cycles), 0);
    check("reset_mem_err", 32'(hz.mem_err), 0);

    // Vector table: single cycles, none long enough to reach the timeout.
    for (int i = 0; i < 11; i++) begin
      drive(vt[i].rst, vt[i].rs1, vt[i].rs2, vt[i].use1, vt[i].use2, vt[i].rd,
            vt[i].ld, vt[i].br, vt[i].busy);
      #1;
      check($sformatf("vec%0d", i),
            32'({hz.pc_stall, hz.if_id_stall, hz.if_id_flush, hz.id_ex_stall, hz.id_ex_flush, hz.ex_mem_stall}),
            32'(vt[i].exp));
      cycle();
    end

    // Load-use on rs1, then the same with ex_rd=0.
    do_reset();
    drive(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    cycle();
    check("lu_bubble", 32'(hz.bubble_count), 1);
    check("lu_stall",  32'(hz.stall_cycles), 1);
    drive(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    cycle();
    check("lu_rd0_stall", 32'(hz.stall_cycles), 1);

    // Branch overriding a load-use hit.
    do_reset();
    drive(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    cycle();
    check("br_flush",  32'(hz.flush_count), 1);
    check("br_bubble", 32'(hz.bubble_count), 0);
    check("br_stall",  32'(hz.stall_cycles), 0);

    // Memory wait holding a branch, then the branch fires.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
      cycle();
    end
    check("wait_flush_held", 32'(hz.flush_count), 0);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    cycle();
    check("wait_stall", 32'(hz.stall_cycles), 3);
    check("wait_flush", 32'(hz.flush_count), 1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      cycle();
    end
    check("wait_rearm_no_err", 32'(hz.mem_err), 0);

    // Timeout after TO consecutive busy edges, sticky until reset.
    do_reset();
    for (int i = 0; i < TO; i++) begin
      drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      cycle();
      check($sformatf("to_err_%0d", i), 32'(hz.mem_err), (i == TO - 1) ? 1 : 0);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 5'd2, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0);
      cycle();
    end
    check("to_sticky", 32'(hz.mem_err), 1);
    check("to_frozen_stall", 32'(hz.stall_cycles), TO);
    check("to_frozen_flush", 32'(hz.flush_count), 0);
    do_reset();
    check("to_clr_err", 32'(hz.mem_err), 0);
    check("to_clr_cnt", 32'(hz.stall_cycles), 0);

    // Counter saturation.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 5'd6, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
      cycle();
    end
    check("sat_stall",  32'(hz.stall_cycles), 15);
    check("sat_bubble", 32'(hz.bubble_count), 15);

    // Random stimulus against the model.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      drive(($urandom_range(0, 59) == 0),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
